// File: rtl/byte_demux24_pkg.sv
// Shared constants and types for the byte-to-24-bit sample demultiplexer.
// The byte counter doubles as the sequencer state: S_B0 is the MSB slot, S_B2 the final byte.
package byte_demux24_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned SAMPLE_BYTES = 3;
  localparam int unsigned SAMPLE_W     = BYTE_W * SAMPLE_BYTES;
  localparam int unsigned CNT_W        = $clog2(SAMPLE_BYTES);

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef logic [CNT_W-1:0]           cnt_t;
  typedef logic [BYTE_W-1:0]          byte_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam cnt_t S_B0 = cnt_t'(0);
  localparam cnt_t S_B1 = cnt_t'(1);
  localparam cnt_t S_B2 = cnt_t'(SAMPLE_BYTES - 1);

  // Appends one byte at the LSB end; the oldest byte ends up as the MSB.
  function automatic sample_t shift_in(input sample_t s, input byte_t b);
    return sample_t'({s[SAMPLE_W-BYTE_W-1:0], b});
  endfunction

endpackage

// File: rtl/byte_demux24_out_slot.sv
// One-entry output slot: a data/valid register loaded by the assembler and drained by a
// valid/ready consumer. A load wins over a drain so back-to-back samples never bubble.
module byte_demux24_out_slot #(
  parameter int unsigned WIDTH = 24
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_ready,
  output logic signed [WIDTH-1:0] o_data,
  output logic                    o_valid
);

  logic signed [WIDTH-1:0] r_data;
  logic                    r_valid;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/byte_demux24.sv
// Assembles MSB-first bytes into signed 24-bit samples and steers each to channel A or B.
// Only the final byte of a sample can stall, and only on its own channel's full slot.
module byte_demux24
  import byte_demux24_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [BYTE_W-1:0]          i_in_byte,
  input  logic                       i_in_sel,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic                       i_flush,
  output logic signed [SAMPLE_W-1:0] o_out_a,
  output logic                       o_out_a_valid,
  input  logic                       i_out_a_ready,
  output logic signed [SAMPLE_W-1:0] o_out_b,
  output logic                       o_out_b_valid,
  input  logic                       i_out_b_ready
);

  cnt_t    r_cnt;
  sample_t r_shreg;
  logic    r_sel;

  logic    w_last;
  logic    w_dest_sel;
  logic    w_dest_valid;
  logic    w_dest_ready;
  logic    w_accept;
  logic    w_load_a;
  logic    w_load_b;
  sample_t w_sample;

  assign w_last = (r_cnt == S_B2);

  // The MSB byte carries its own select; later bytes follow the latched one.
  assign w_dest_sel   = (r_cnt == S_B0) ? i_in_sel : r_sel;
  assign w_dest_valid = (w_dest_sel == CH_B) ? o_out_b_valid : o_out_a_valid;
  assign w_dest_ready = (w_dest_sel == CH_B) ? i_out_b_ready : i_out_a_ready;

  assign o_in_ready = !i_flush && !(w_last && w_dest_valid && !w_dest_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_sample   = shift_in(r_shreg, i_in_byte);

  assign w_load_a = w_accept && w_last && (w_dest_sel == CH_A);
  assign w_load_b = w_accept && w_last && (w_dest_sel == CH_B);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= S_B0;
      r_shreg <= '0;
      r_sel   <= CH_A;
    end else if (i_flush) begin
      r_cnt <= S_B0;
    end else if (w_accept) begin
      r_shreg <= w_sample;
      if (r_cnt == S_B0) begin
        r_sel <= i_in_sel;
      end
      r_cnt <= w_last ? S_B0 : r_cnt + cnt_t'(1);
    end
  end

  byte_demux24_out_slot #(
    .WIDTH (SAMPLE_W)
  ) u_slot_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load_a),
    .i_data  (w_sample),
    .i_ready (i_out_a_ready),
    .o_data  (o_out_a),
    .o_valid (o_out_a_valid)
  );

  byte_demux24_out_slot #(
    .WIDTH (SAMPLE_W)
  ) u_slot_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load_b),
    .i_data  (w_sample),
    .i_ready (i_out_b_ready),
    .o_data  (o_out_b),
    .o_valid (o_out_b_valid)
  );

endmodule
